i2c_stim_sequencer: RTL and testbench

Command-driven AXI-Stream frame generator that feeds the testbench's routing demultiplexer. For each accepted command it drives the 3-bit target select (1 = master1, 2 = master2, 3 = slave1, 4 = slave2, 5 = slave3) and emits a frame of arithmetic-progression bytes with `tvalid`/`tlast`, honouring the target's `tready` as returned through the demux. Select is held stable for the whole frame and returned to 0 (no target) between frames.

---
 rtl/i2c_stim_sequencer_if.sv | 28 ++
 rtl/i2c_stim_sequencer.sv | 122 ++++++++++++
 tb/tb_i2c_stim_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_stim_sequencer_if.sv
// Command and stream bundle for the stimulus sequencer.
// The master modport is the sequencer side; the slave modport is the
// environment that issues commands and returns the routed tready.
interface i2c_stim_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_sel;
   logic [LEN_W-1:0] cmd_len;
   logic [7:0]       cmd_seed;
   logic [7:0]       cmd_step;
   logic [2:0]       sel;
   logic [7:0]       tdata;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport master (
      input  cmd_valid, cmd_sel, cmd_len, cmd_seed, cmd_step, tready,
      output cmd_ready, sel, tdata, tvalid, tlast
   );

   modport slave (
      output cmd_valid, cmd_sel, cmd_len, cmd_seed, cmd_step, tready,
      input  cmd_ready, sel, tdata, tvalid, tlast
   );
endinterface

// File: rtl/i2c_stim_sequencer.sv
// Command-driven AXI-Stream frame generator. Each legal command selects a
// demux target, waits one settle cycle, streams an arithmetic-progression
// frame, then idles GAP_CYCLES cycles with no target selected.
module i2c_stim_sequencer #(
   parameter int LEN_W      = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   i2c_stim_sequencer_if.master bus,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err_bad_cmd,
   output logic [15:0]          frame_count
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STREAM,
      GAP
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;   // bytes still to hand over, including the current one
   logic [7:0]       step;        // per-byte increment latched at acceptance
   logic [GAP_W-1:0] gap_cnt;     // GAP cycles left after the current one
   logic             bad_cmd;

   // An illegal target id or a zero-length frame is dropped at acceptance.
   assign bad_cmd = (bus.cmd_sel == 3'd0) || (bus.cmd_sel > 3'd5) ||
                    (bus.cmd_len == '0);

   // NOTE: cmd_ready is decoded straight from the state register so it reads 1
   // for the whole time reset is held, with no extra register to clear.
   assign bus.cmd_ready = (state == IDLE);

   // Sequencer state machine with all bus and status outputs registered.
   // NOTE: every state and output register uses non-blocking assignments so
   // each branch sees the pre-edge values of tdata, tlast and remaining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         remaining   <= '0;
         step        <= '0;
         gap_cnt     <= '0;
         bus.sel     <= 3'd0;
         bus.tdata   <= 8'd0;
         bus.tvalid  <= 1'b0;
         bus.tlast   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         err_bad_cmd <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         frame_done  <= 1'b0;
         err_bad_cmd <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  if (bad_cmd) begin
                     err_bad_cmd <= 1'b1;
                  end else begin
                     // The seed is parked in tdata now; tvalid stays low
                     // through SETUP so nothing is presented yet.
                     remaining <= bus.cmd_len;
                     step      <= bus.cmd_step;
                     bus.tdata <= bus.cmd_seed;
                     bus.sel   <= bus.cmd_sel;
                     busy      <= 1'b1;
                     state     <= SETUP;
                  end
               end
            end

            SETUP: begin
               bus.tvalid <= 1'b1;
               bus.tlast  <= (remaining == LEN_W'(1));
               state      <= STREAM;
            end

            STREAM: begin
               if (bus.tvalid && bus.tready) begin
                  if (bus.tlast) begin
                     bus.tvalid  <= 1'b0;
                     bus.tlast   <= 1'b0;
                     bus.sel     <= 3'd0;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     if (GAP_CYCLES == 0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end
                  end else begin
                     bus.tdata <= bus.tdata + step;
                     remaining <= remaining - LEN_W'(1);
                     bus.tlast <= (remaining == LEN_W'(2));
                  end
               end
            end

            GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_stim_sequencer.sv
// Scoreboard bench for i2c_stim_sequencer: expected beats are queued when a
// command is issued and popped as the DUT hands bytes over.
module tb_i2c_stim_sequencer;

   localparam int LEN_W      = 8;
   localparam int GAP_CYCLES = 4;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic        frame_done;
   logic        err_bad_cmd;
   logic [15:0] frame_count;

   beat_t       exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] exp_frames  = 16'd0;

   i2c_stim_sequencer_if #(.LEN_W(LEN_W)) bus ();

   i2c_stim_sequencer #(
      .LEN_W      (LEN_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_bad_cmd (err_bad_cmd),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed and expected differ.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   // tready pattern: a set mask bit stalls that cycle (relative to acceptance).
   function automatic logic ready_at(input logic [63:0] mask, input int c);
      if (c >= 64) return 1'b1;
      return !mask[c];
   endfunction

   // Issue one legal command and follow the frame through to cmd_ready.
   task automatic do_frame(input logic [2:0] s, input logic [7:0] len,
                           input logic [7:0] seed, input logic [7:0] stp,
                           input logic [63:0] low_mask);
      beat_t      b;
      beat_t      e;
      logic [7:0] d;
      int         cyc;
      int         beats;
      int         done_cyc;
      int         c;
      logic       prev_stall;
      logic [7:0] prev_data;

      d = seed;
      for (int i = 0; i < int'(len); i++) begin
         b.sel  = s;
         b.data = d;
         b.last = (i == int'(len) - 1);
         exp_q.push_back(b);
         d = d + stp;
      end
      cyc   = 2;
      beats = 0;
      while (beats < int'(len)) begin
         if (ready_at(low_mask, cyc)) beats++;
         cyc++;
      end
      done_cyc = cyc;

      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = s;
      bus.cmd_len   = len;
      bus.cmd_seed  = seed;
      bus.cmd_step  = stp;
      bus.tready    = ready_at(low_mask, 0);
      step_cycle();
      c = 1;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = 3'($urandom);
      bus.cmd_seed  = 8'($urandom);
      check("setup_sel", bus.sel, s);
      check("setup_busy", busy, 1);
      check("setup_tvalid", bus.tvalid, 0);
      check("setup_cmd_ready", bus.cmd_ready, 0);
      check("setup_err", err_bad_cmd, 0);

      prev_stall = 1'b0;
      prev_data  = 8'd0;
      while (c < 200) begin
         bus.tready = ready_at(low_mask, c);
         if (frame_done) break;
         check("frame_sel", bus.sel, s);
         check("frame_busy", busy, 1);
         if (c == 2) check("first_beat_valid", bus.tvalid, 1);
         if (prev_stall) begin
            check("stall_tvalid_held", bus.tvalid, 1);
            check("stall_tdata_held", bus.tdata, prev_data);
         end
         if (bus.tvalid && bus.tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", bus.tvalid, 0);
            end else begin
               e = exp_q.pop_front();
               check("tdata", bus.tdata, e.data);
               check("tlast", bus.tlast, e.last);
            end
         end
         prev_stall = bus.tvalid && !bus.tready;
         prev_data  = bus.tdata;
         step_cycle();
         c++;
      end

      if (frame_done) begin
         exp_frames = exp_frames + 16'd1;
         check("done_cycle", c, done_cyc);
         check("done_sel", bus.sel, 0);
         check("done_tvalid", bus.tvalid, 0);
         check("frame_count", frame_count, exp_frames);
         check("beats_left", exp_q.size(), 0);
      end else begin
         check("done_timeout", frame_done, 1);
      end
      exp_q.delete();

      while (!bus.cmd_ready && c < done_cyc + 50) begin
         check("gap_sel", bus.sel, 0);
         check("gap_tvalid", bus.tvalid, 0);
         check("gap_busy", busy, 1);
         step_cycle();
         c++;
      end
      check("ready_cycle", c, done_cyc + GAP_CYCLES);
      check("idle_busy", busy, 0);
      check("idle_done_pulse", frame_done, 0);
   endtask

   // Issue one illegal command and confirm it is dropped with an error pulse.
   task automatic bad_cmd(input logic [2:0] s, input logic [7:0] len);
      check("bad_ready_before", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = s;
      bus.cmd_len   = len;
      bus.cmd_seed  = 8'h55;
      bus.cmd_step  = 8'h01;
      step_cycle();
      bus.cmd_valid = 1'b0;
      check("bad_err", err_bad_cmd, 1);
      check("bad_busy", busy, 0);
      check("bad_ready_after", bus.cmd_ready, 1);
      check("bad_tvalid", bus.tvalid, 0);
      step_cycle();
      check("bad_err_pulse", err_bad_cmd, 0);
      check("bad_tvalid_later", bus.tvalid, 0);
      check("bad_frame_count", frame_count, exp_frames);
   endtask

   // Outputs that must all be at their reset values.
   task automatic check_reset_values(input string tag);
      check({tag, "_sel"}, bus.sel, 0);
      check({tag, "_tdata"}, bus.tdata, 0);
      check({tag, "_tvalid"}, bus.tvalid, 0);
      check({tag, "_tlast"}, bus.tlast, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_err"}, err_bad_cmd, 0);
      check({tag, "_frame_count"}, frame_count, 0);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = 3'd0;
      bus.cmd_len   = '0;
      bus.cmd_seed  = 8'd0;
      bus.cmd_step  = 8'd0;
      bus.tready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst_held");
      rst_n = 1'b1;
      step_cycle();
      check_reset_values("rst_released");

      // Basic frame on slave1.
      do_frame(3'd3, 8'd4, 8'h10, 8'h01, 64'h0);
      // Wrapping data with tready low in cycles 3 and 4.
      do_frame(3'd1, 8'd3, 8'hFE, 8'h01, 64'h18);

      // Illegal commands.
      bad_cmd(3'd0, 8'd4);
      bad_cmd(3'd6, 8'd4);
      bad_cmd(3'd2, 8'd0);
      bad_cmd(3'd7, 8'd2);

      // Single-byte frame.
      do_frame(3'd5, 8'd1, 8'hAA, 8'h00, 64'h0);

      // A few random frames with random back-pressure.
      for (int n = 0; n < 6; n++) begin
         do_frame(3'($urandom_range(1, 5)), 8'($urandom_range(1, 12)),
                  8'($urandom), 8'($urandom),
                  {$urandom, $urandom} & {$urandom, $urandom} & ~64'h3);
      end

      // Reset asserted during the fourth beat of an 8-byte frame.
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = 3'd4;
      bus.cmd_len   = 8'd8;
      bus.cmd_seed  = 8'h20;
      bus.cmd_step  = 8'h03;
      bus.tready    = 1'b1;
      step_cycle();
      bus.cmd_valid = 1'b0;
      repeat (4) step_cycle();
      check("mid_frame_tdata", bus.tdata, 8'h29);
      check("mid_frame_tvalid", bus.tvalid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_async");
      step_cycle();
      check_reset_values("rst_hold");
      rst_n      = 1'b1;
      exp_frames = 16'd0;
      step_cycle();
      check_reset_values("rst_after");
      do_frame(3'd2, 8'd2, 8'h40, 8'h10, 64'h0);

      // Counter wrap: preload near the top, then complete two frames.
      force dut.frame_count = 16'hFFFE;
      #1;
      release dut.frame_count;
      #1;
      check("wrap_preset", frame_count, 16'hFFFE);
      exp_frames = 16'hFFFE;
      do_frame(3'd5, 8'd1, 8'h01, 8'h00, 64'h0);
      do_frame(3'd5, 8'd1, 8'h02, 8'h00, 64'h0);
      check("wrap_zero", frame_count, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
